tuple_array_permuter: RTL and testbench
=======================================

Name: tuple_array_permuter

Overview:
- Registered, reconfigurable permutation block for an array of N two-field tuples. Field 0 is W0 bits wide and field 1 is W1 bits wide.
- Each field has its own independent permutation table, so the two fields can be routed differently.
- Input and output use valid/ready handshakes, with a 2-entry output buffer.
- Used between array-of-tuple producers and consumers wherever lane reordering must change at run time.
- Reset tables give the default mapping: field 0 reversed across lanes, field 1 identity.

Parameters:
- N, 4, number of array elements (lanes), N >= 2.
- W0, 1, width of tuple field 0.
- W1, 2, width of tuple field 1.
- SW, clog2(N), width of one lane-select entry (derived, not overridable).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- I_valid  input  1  input tuple array valid.
- I_ready  output  1  block accepts input this cycle.
- I_f0  input  N*W0  field 0 of all lanes; lane k at bits [k*W0 +: W0].
- I_f1  input  N*W1  field 1 of all lanes; lane k at bits [k*W1 +: W1].
- O_valid  output  1  output array valid.
- O_ready  input  1  downstream accepts output.
- O_f0  output  N*W0  permuted field 0.
- O_f1  output  N*W1  permuted field 1.
- cfg_valid  input  1  new permutation tables offered.
- cfg_ready  output  1  tables captured this cycle.
- cfg_sel0  input  N*SW  field 0 table; entry j is the source lane for output lane j.
- cfg_sel1  input  N*SW  field 1 table, same format.
- cfg_err  output  1  sticky flag: last loaded table contained an entry >= N.

Behaviour:
- Reset (async assert, held while ASYNCRESET=1) sets:
  - state=RUN, buffer empty.
  - O_valid=0, I_ready=0 while reset is asserted.
  - cfg_ready=0, cfg_err=0, O_f0/O_f1=0.
  - tab0[j]=N-1-j, tab1[j]=j.
- Permutation, computed combinationally at the input from the current tables:
  - out lane j field0 = I_f0 lane tab0[j].
  - out lane j field1 = I_f1 lane tab1[j].
  - A table entry >= N drives that lane/field to zero.
  - Non-bijective tables (duplicate sources) are legal: broadcast.
- Input handshake and latency:
  - Transfer occurs when I_valid && I_ready.
  - The permuted word enters the 2-entry FIFO at the clock edge.
  - O_valid goes high the next cycle (latency 1).
  - I_ready = (state==RUN) && (count<2 || (count==2 && O_ready)). Full throughput with O_ready held high.
- Output handshake:
  - Head is popped when O_valid && O_ready.
  - O_f0/O_f1 show the head entry, held stable while O_valid && !O_ready.
  - Simultaneous push and pop leaves count unchanged, order preserved.
- Input rules: I_f0/I_f1 are sampled only on transfer. I_valid must not drop before transfer (protocol requirement, not checked).
- State machine:
  - RUN: normal operation. cfg_valid=1 → DRAIN (the input may still transfer in that same cycle).
  - DRAIN: I_ready=0, buffer keeps emptying. count==0 → APPLY.
  - APPLY: I_ready=0 and cfg_ready=1 for exactly this one cycle. At the edge:
    - tab0 ← cfg_sel0, tab1 ← cfg_sel1.
    - cfg_err ← (any entry >= N).
    - Next state RUN.
  - Entries are in flight with the old tables until drained; no word ever mixes old and new tables.
- Config data: cfg_sel0/1 must be stable while cfg_valid=1. If cfg_valid drops during DRAIN, APPLY still captures the values present in the APPLY cycle.
- Reset mid-operation: buffer contents discarded, tables revert to defaults, and any pending config is abandoned.

Test Plan:
1. Default tables, N=4:
   - Stimulus: I_f0=4'b0001 (lane0=1), I_f1={2'd3,2'd2,2'd1,2'd0}, one transfer.
   - Required: next cycle O_valid=1, O_f0=4'b1000, O_f1 identical to input.
2. Streaming and backpressure:
   - Stimulus: 8 back-to-back words with O_ready=1, then O_ready=0 for 3 cycles.
   - Required: one output per cycle. After the 2nd word buffered during the stall, I_ready=0. No loss or reorder once O_ready returns.
3. Reconfiguration:
   - Stimulus: with 2 words buffered, assert cfg_valid with cfg_sel0=cfg_sel1={0,0,0,0} (broadcast lane0) under O_ready=1.
   - Required: both old words exit with default mapping, cfg_ready pulses once, cfg_err=0. Next input I_f1 lane0=2'd2 yields O_f1=8'hAA.
4. Out-of-range select (N=3, SW=2):
   - Stimulus: load an entry=3.
   - Required: cfg_err=1 and that output lane reads zero. A subsequent valid load clears cfg_err.
5. Async reset mid-stream:
   - Stimulus: assert ASYNCRESET between clock edges with the buffer full.
   - Required: O_valid=0 immediately, the buffer is empty after release, and default tables are restored (scenario 1 response repeats).

Source files
------------

// File: rtl/tuple_array_permuter.sv
// Registered per-field lane permuter for an array of two-field tuples.
// Run-time tables are swapped only after the 2-entry output buffer drains.
module tuple_array_permuter #(
  parameter int N = 4,
  parameter int W0 = 1,
  parameter int W1 = 2,
  localparam int SW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            ASYNCRESET,
  input  logic            I_valid,
  output logic            I_ready,
  input  logic [N*W0-1:0] I_f0,
  input  logic [N*W1-1:0] I_f1,
  output logic            O_valid,
  input  logic            O_ready,
  output logic [N*W0-1:0] O_f0,
  output logic [N*W1-1:0] O_f1,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [N*SW-1:0] cfg_sel0,
  input  logic [N*SW-1:0] cfg_sel1,
  output logic            cfg_err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SW-1:0]   r_tab0 [N];
  logic [SW-1:0]   r_tab1 [N];
  logic            r_err;
  logic [N*W0-1:0] r_m0 [2];
  logic [N*W1-1:0] r_m1 [2];
  logic            r_rp;
  logic            r_wp;
  logic [1:0]      r_cnt;

  logic [N*W0-1:0] w_p0;
  logic [N*W1-1:0] w_p1;
  logic            w_bad;
  logic            w_push;
  logic            w_pop;

  // Entries matching no lane leave the output lane at zero.
  always_comb begin
    w_p0 = '0;
    w_p1 = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (r_tab0[j] == SW'(k))
          w_p0[j*W0 +: W0] = I_f0[k*W0 +: W0];
        if (r_tab1[j] == SW'(k))
          w_p1[j*W1 +: W1] = I_f1[k*W1 +: W1];
      end
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (int'(cfg_sel0[j*SW +: SW]) >= N)
        w_bad = 1'b1;
      if (int'(cfg_sel1[j*SW +: SW]) >= N)
        w_bad = 1'b1;
    end
  end

  assign O_valid = (r_cnt != 2'd0);
  assign O_f0    = r_m0[r_rp];
  assign O_f1    = r_m1[r_rp];
  assign cfg_err = r_err;
  assign w_push  = I_valid & I_ready;
  assign w_pop   = O_valid & O_ready;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:     if (cfg_valid) w_next = DRAIN;
      DRAIN:   if (r_cnt == 2'd0) w_next = APPLY;
      APPLY:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    I_ready   = 1'b0;
    cfg_ready = 1'b0;
    unique case (r_state)
      RUN:     I_ready = !ASYNCRESET &&
                         (r_cnt != 2'd2 || O_ready);
      APPLY:   cfg_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_rp  <= 1'b0;
      r_wp  <= 1'b0;
      r_cnt <= 2'd0;
      r_m0[0] <= '0;
      r_m0[1] <= '0;
      r_m1[0] <= '0;
      r_m1[1] <= '0;
    end else begin
      if (w_push) begin
        r_m0[r_wp] <= w_p0;
        r_m1[r_wp] <= w_p1;
        r_wp <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push}
                     - {1'b0, w_pop};
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_err <= 1'b0;
      for (int j = 0; j < N; j++) begin
        r_tab0[j] <= SW'(N - 1 - j);
        r_tab1[j] <= SW'(j);
      end
    end else if (r_state == APPLY) begin
      r_err <= w_bad;
      for (int j = 0; j < N; j++) begin
        r_tab0[j] <= cfg_sel0[j*SW +: SW];
        r_tab1[j] <= cfg_sel1[j*SW +: SW];
      end
    end
  end

endmodule

// File: tb/tb_tuple_array_permuter.sv
// Bench for tuple_array_permuter: queue reference model, N=4 and N=3 instances.
// Outputs are sampled on the falling edge; inputs change just after rising edges.
module tb_tuple_array_permuter;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  logic       iv = 0, irdy, ov, ordy = 1, cv = 0, crdy, cerr;
  logic [3:0] if0 = 0, of0;
  logic [7:0] if1 = 0, of1, cs0 = 0, cs1 = 0;

  logic       iv3 = 0, irdy3, ov3, ordy3 = 1, cv3 = 0, crdy3, cerr3;
  logic [2:0] if0_3 = 0, of0_3;
  logic [5:0] if1_3 = 0, of1_3, cs0_3 = 0, cs1_3 = 0;

  tuple_array_permuter #(.N(4), .W0(1), .W1(2)) dut (
    .CLK(CLK), .ASYNCRESET(rst),
    .I_valid(iv), .I_ready(irdy), .I_f0(if0), .I_f1(if1),
    .O_valid(ov), .O_ready(ordy), .O_f0(of0), .O_f1(of1),
    .cfg_valid(cv), .cfg_ready(crdy),
    .cfg_sel0(cs0), .cfg_sel1(cs1), .cfg_err(cerr)
  );

  tuple_array_permuter #(.N(3), .W0(1), .W1(2)) dut3 (
    .CLK(CLK), .ASYNCRESET(rst),
    .I_valid(iv3), .I_ready(irdy3), .I_f0(if0_3), .I_f1(if1_3),
    .O_valid(ov3), .O_ready(ordy3), .O_f0(of0_3), .O_f1(of1_3),
    .cfg_valid(cv3), .cfg_ready(crdy3),
    .cfg_sel0(cs0_3), .cfg_sel1(cs1_3), .cfg_err(cerr3)
  );

  int nvec = 0;
  int nerr = 0;
  logic [11:0] q[$];
  logic [7:0]  mt0 = 8'h1B;
  logic [7:0]  mt1 = 8'hE4;
  logic        merr = 1'b0;
  int          rmode = 0;
  int          crdy_seen = 0;
  logic        g_push = 1'b0;

  // Reference: out lane j takes in lane s[j]; out-of-range source reads zero.
  function automatic logic [11:0] perm(input int n, input logic [3:0] a,
    input logic [7:0] b, input logic [7:0] s0, input logic [7:0] s1);
    logic [3:0] r0;
    logic [7:0] r1;
    int e0, e1;
    r0 = '0;
    r1 = '0;
    for (int j = 0; j < n; j++) begin
      e0 = int'(s0[2*j +: 2]);
      e1 = int'(s1[2*j +: 2]);
      if (e0 < n) r0[j] = a[e0];
      if (e1 < n) r1[2*j +: 2] = b[2*e1 +: 2];
    end
    return {r0, r1};
  endfunction

  function automatic logic bad(input int n, input logic [7:0] s);
    for (int j = 0; j < n; j++)
      if (int'(s[2*j +: 2]) >= n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    logic pu, po, app, exp_rdy;
    @(negedge CLK);
    nvec++;
    if (ov !== (q.size() != 0)) begin
      nerr++;
      $display("FAIL o_valid: got %b want %b", ov, q.size() != 0);
    end
    if (q.size() != 0) begin
      nvec++;
      if ({of0, of1} !== q[0]) begin
        nerr++;
        $display("FAIL o_data: got %h want %h", {of0, of1}, q[0]);
      end
    end
    nvec++;
    if (cerr !== merr) begin
      nerr++;
      $display("FAIL cfg_err: got %b want %b", cerr, merr);
    end
    if (rmode == 0) begin
      exp_rdy = (q.size() < 2) || ordy;
      nvec++;
      if (irdy !== exp_rdy) begin
        nerr++;
        $display("FAIL i_ready: got %b want %b", irdy, exp_rdy);
      end
      nvec++;
      if (crdy !== 1'b0) begin
        nerr++;
        $display("FAIL cfg_ready_idle: got %b want 0", crdy);
      end
    end else if (rmode == 1) begin
      nvec++;
      if (irdy !== 1'b0) begin
        nerr++;
        $display("FAIL i_ready_blocked: got %b want 0", irdy);
      end
    end
    pu = iv && irdy;
    po = ov && ordy;
    app = (crdy === 1'b1);
    if (app) crdy_seen++;
    @(posedge CLK);
    if (po && q.size() != 0) void'(q.pop_front());
    if (pu) q.push_back(perm(4, if0, if1, mt0, mt1));
    if (app) begin
      mt0 = cs0;
      mt1 = cs1;
      merr = bad(4, cs0) | bad(4, cs1);
    end
    g_push = pu;
    #1;
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({ov, irdy, crdy, cerr} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_ctl: got %b want 0000", {ov, irdy, crdy, cerr});
    end
    nvec++;
    if ({of0, of1} !== 12'h000) begin
      nerr++;
      $display("FAIL reset_data: got %h want 000", {of0, of1});
    end
    nvec++;
    if ({ov3, irdy3, cerr3} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_n3: got %b want 000", {ov3, irdy3, cerr3});
    end
    @(posedge CLK);
    #1 rst = 1'b0;
  endtask

  task automatic test_default();
    ordy = 1;
    iv = 1;
    if0 = 4'b0001;
    if1 = 8'hE4;
    step();
    iv = 0;
    #1;
    nvec++;
    if ({ov, of0, of1} !== {1'b1, 4'b1000, 8'hE4}) begin
      nerr++;
      $display("FAIL default_map: got %b/%h/%h want 1/8/e4", ov, of0, of1);
    end
    step();
    step();
  endtask

  task automatic test_stream();
    ordy = 1;
    for (int i = 0; i < 8; i++) begin
      iv = 1;
      if0 = 4'($urandom);
      if1 = 8'($urandom);
      step();
    end
    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      if (!(iv && !g_push)) begin
        if0 = 4'($urandom);
        if1 = 8'($urandom);
      end
      step();
    end
    nvec++;
    if (irdy !== 1'b0) begin
      nerr++;
      $display("FAIL stall_ready: got %b want 0", irdy);
    end
    iv = 0;
    ordy = 1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (!(iv && !g_push)) begin
        iv = ($urandom % 4) != 0;
        if0 = 4'($urandom);
        if1 = 8'($urandom);
      end
      ordy = ($urandom % 3) != 0;
      step();
    end
    iv = 0;
    ordy = 1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reconfig();
    ordy = 0;
    iv = 1;
    for (int i = 0; i < 2; i++) begin
      if0 = 4'($urandom);
      if1 = 8'($urandom);
      step();
    end
    iv = 0;
    ordy = 1;
    cv = 1;
    cs0 = 8'h00;
    cs1 = 8'h00;
    crdy_seen = 0;
    step();
    rmode = 1;
    for (int i = 0; i < 20 && crdy_seen == 0; i++) step();
    cv = 0;
    rmode = 0;
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL reconf_drain: got %0d left want 0", q.size());
    end
    for (int i = 0; i < 3; i++) step();
    nvec++;
    if (crdy_seen != 1) begin
      nerr++;
      $display("FAIL cfg_ready_pulse: got %0d want 1", crdy_seen);
    end
    iv = 1;
    if0 = 4'($urandom);
    if1 = 8'h02;
    step();
    iv = 0;
    #1;
    nvec++;
    if ({ov, of1} !== {1'b1, 8'hAA}) begin
      nerr++;
      $display("FAIL broadcast: got %b/%h want 1/aa", ov, of1);
    end
    step();
    step();
  endtask

  task automatic cfg3(input logic [5:0] s0, input logic [5:0] s1);
    logic got;
    got = 1'b0;
    cv3 = 1;
    cs0_3 = s0;
    cs1_3 = s1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      got = (crdy3 === 1'b1);
    end
    @(posedge CLK);
    #1 cv3 = 0;
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL cfg3_timeout: got 0 want 1");
    end
  endtask

  task automatic push3(input string nm);
    logic [11:0] e;
    e = perm(3, {1'b0, if0_3}, {2'b0, if1_3},
             {2'b0, cs0_3}, {2'b0, cs1_3});
    iv3 = 1;
    ordy3 = 1;
    @(negedge CLK);
    @(posedge CLK);
    #1 iv3 = 0;
    nvec++;
    if ({ov3, 1'b0, of0_3, 2'b0, of1_3} !== {1'b1, e}) begin
      nerr++;
      $display("FAIL %s: got %b/%h/%h want 1/%h", nm, ov3, of0_3, of1_3, e);
    end
  endtask

  task automatic test_oor();
    cfg3({2'd3, 2'd1, 2'd0}, {2'd0, 2'd1, 2'd2});
    nvec++;
    if (cerr3 !== 1'b1) begin
      nerr++;
      $display("FAIL oor_err: got %b want 1", cerr3);
    end
    if0_3 = 3'b111;
    if1_3 = {2'd3, 2'd2, 2'd1};
    push3("oor_f0");
    nvec++;
    if ({of0_3, of1_3} !== {3'b011, 6'h1B}) begin
      nerr++;
      $display("FAIL oor_lane: got %h/%h want 3/1b", of0_3, of1_3);
    end
    cfg3({2'd2, 2'd1, 2'd0}, {2'd1, 2'd3, 2'd0});
    nvec++;
    if (cerr3 !== 1'b1) begin
      nerr++;
      $display("FAIL oor_err1: got %b want 1", cerr3);
    end
    if0_3 = 3'($urandom);
    if1_3 = 6'($urandom) | 6'h30;
    push3("oor_f1");
    cfg3({2'd2, 2'd1, 2'd0}, {2'd2, 2'd1, 2'd0});
    nvec++;
    if (cerr3 !== 1'b0) begin
      nerr++;
      $display("FAIL oor_clear: got %b want 0", cerr3);
    end
  endtask

  task automatic test_async_reset();
    ordy = 0;
    iv = 1;
    for (int i = 0; i < 2; i++) begin
      if0 = 4'($urandom);
      if1 = 8'($urandom);
      step();
    end
    iv = 0;
    #3 rst = 1'b1;
    #1;
    nvec++;
    if ({ov, irdy, crdy} !== 3'b000) begin
      nerr++;
      $display("FAIL async_ctl: got %b want 000", {ov, irdy, crdy});
    end
    nvec++;
    if ({of0, of1} !== 12'h000) begin
      nerr++;
      $display("FAIL async_data: got %h want 000", {of0, of1});
    end
    q.delete();
    mt0 = 8'h1B;
    mt1 = 8'hE4;
    merr = 1'b0;
    @(posedge CLK);
    #2 rst = 1'b0;
    ordy = 1;
    step();
    test_default();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_stream();
    test_random();
    test_reconfig();
    test_oor();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
